// File: rtl/branch_resolve_update_if.sv
// Handshake bundle between decode/execute/BTB-write and the branch resolve unit.
// slave = resolve unit side, master = surrounding pipeline side.
interface branch_resolve_update_if #(
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                  push_valid;
    logic                  push_ready;
    logic [ADDR_WIDTH-1:0] push_pc;
    logic                  push_pred_taken;
    logic [ADDR_WIDTH-1:0] push_pred_target;

    logic                  res_valid;
    logic                  res_ready;
    logic                  res_taken;
    logic [ADDR_WIDTH-1:0] res_target;

    logic                  redirect_valid;
    logic [ADDR_WIDTH-1:0] redirect_pc;

    logic                  upd_valid;
    logic                  upd_ready;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic [ADDR_WIDTH-1:0] upd_target;

    modport master (
        output push_valid, push_pc, push_pred_taken, push_pred_target,
        output res_valid, res_taken, res_target, upd_ready,
        input  push_ready, res_ready, redirect_valid, redirect_pc,
        input  upd_valid, upd_pc, upd_target
    );

    modport slave (
        input  push_valid, push_pc, push_pred_taken, push_pred_target,
        input  res_valid, res_taken, res_target, upd_ready,
        output push_ready, res_ready, redirect_valid, redirect_pc,
        output upd_valid, upd_pc, upd_target
    );
endinterface

// File: rtl/branch_resolve_update.sv
// In-order prediction record FIFO; resolves the head against execute results,
// issues fetch redirects on mispredict and queues BTB write requests.
module branch_resolve_update #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    branch_resolve_update_if.slave     bus,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_WIDTH-1:0]       mp_count
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned OCC_W = $clog2(DEPTH + 1);

    logic [ADDR_WIDTH-1:0] pc_mem  [DEPTH];
    logic [ADDR_WIDTH-1:0] tgt_mem [DEPTH];
    logic [DEPTH-1:0]      taken_mem;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;

    logic                  push_fire;
    logic                  res_fire;
    logic                  mispredict;
    logic                  flush;
    logic                  head_taken;
    logic [ADDR_WIDTH-1:0] head_pc;
    logic [ADDR_WIDTH-1:0] head_tgt;
    logic [ADDR_WIDTH-1:0] correct_pc;

    assign bus.push_ready = (occupancy < OCC_W'(DEPTH));
    // Resolution waits while a BTB write is held, so an update is never overwritten.
    assign bus.res_ready  = (occupancy != '0) && (!bus.upd_valid || bus.upd_ready);

    assign push_fire = bus.push_valid && bus.push_ready;
    assign res_fire  = bus.res_valid && bus.res_ready;

    always_comb begin
        head_pc    = pc_mem[rd_ptr];
        head_tgt   = tgt_mem[rd_ptr];
        head_taken = taken_mem[rd_ptr];
        mispredict = (head_taken != bus.res_taken) ||
                     (head_taken && bus.res_taken && (head_tgt != bus.res_target));
        correct_pc = bus.res_taken ? bus.res_target : head_pc + ADDR_WIDTH'(4);
        flush      = res_fire && mispredict;
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[wr_ptr]    <= bus.push_pc;
            tgt_mem[wr_ptr]   <= bus.push_pred_target;
            taken_mem[wr_ptr] <= bus.push_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            occupancy          <= '0;
            mp_count           <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.upd_valid      <= 1'b0;
            bus.upd_pc         <= '0;
            bus.upd_target     <= '0;
        end else begin
            bus.redirect_valid <= flush;
            if (flush) begin
                bus.redirect_pc <= correct_pc;
                if (mp_count != '1) begin
                    mp_count <= mp_count + CNT_WIDTH'(1);
                end
            end

            // Loading a new update takes priority over clearing the accepted one.
            if (flush && bus.res_taken) begin
                bus.upd_valid  <= 1'b1;
                bus.upd_pc     <= head_pc;
                bus.upd_target <= bus.res_target;
            end else if (bus.upd_valid && bus.upd_ready) begin
                bus.upd_valid <= 1'b0;
            end

            if (flush) begin
                wr_ptr    <= '0;
                rd_ptr    <= '0;
                occupancy <= '0;
            end else begin
                if (push_fire) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (res_fire) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                if (push_fire && !res_fire) begin
                    occupancy <= occupancy + OCC_W'(1);
                end else if (!push_fire && res_fire) begin
                    occupancy <= occupancy - OCC_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_update.sv
// Directed + short random bench for branch_resolve_update with a queue-based scoreboard.
module tb_branch_resolve_update;
    localparam int unsigned AW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CW     = 4;
    localparam int unsigned MP_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [2:0]    occupancy;
    logic [CW-1:0] mp_count;
    logic          upd_rdy;

    branch_resolve_update_if #(.ADDR_WIDTH(AW)) bus ();

    branch_resolve_update #(
        .ADDR_WIDTH(AW),
        .DEPTH(DEPTH),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .occupancy(occupancy),
        .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic          taken;
        logic [AW-1:0] tgt;
    } rec_t;

    rec_t            fifo_m[$];
    logic [AW-1:0]   exp_redir[$];
    logic [2*AW-1:0] exp_upd[$];
    int unsigned     mp_m;
    int              tests;
    int              fails;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic post_check();
        logic [2*AW-1:0] u;
        logic [AW-1:0]   r;
        chk("redirect_valid", 64'(bus.redirect_valid), 64'(exp_redir.size() != 0));
        if (exp_redir.size() != 0) begin
            r = exp_redir.pop_front();
            chk("redirect_pc", 64'(bus.redirect_pc), 64'(r));
        end
        chk("upd_valid", 64'(bus.upd_valid), 64'(exp_upd.size() != 0));
        if (exp_upd.size() != 0) begin
            u = exp_upd[0];
            chk("upd_pc", 64'(bus.upd_pc), 64'(u[2*AW-1:AW]));
            chk("upd_target", 64'(bus.upd_target), 64'(u[AW-1:0]));
        end
        chk("occupancy", 64'(occupancy), 64'(fifo_m.size()));
        chk("mp_count", 64'(mp_count), 64'((mp_m > MP_MAX) ? MP_MAX : mp_m));
    endtask

    // One clock: drive at negedge, model the edge, check after the edge.
    task automatic cycle(input logic pv, input logic [AW-1:0] ppc, input logic pt,
                         input logic [AW-1:0] ptg, input logic rv, input logic rt,
                         input logic [AW-1:0] rtg);
        rec_t          h;
        logic          pr_e;
        logic          rr_e;
        logic          mp;
        logic [AW-1:0] cpc;
        bus.push_valid       = pv;
        bus.push_pc          = ppc;
        bus.push_pred_taken  = pt;
        bus.push_pred_target = ptg;
        bus.res_valid        = rv;
        bus.res_taken        = rt;
        bus.res_target       = rtg;
        bus.upd_ready        = upd_rdy;
        #1;
        pr_e = (fifo_m.size() < DEPTH);
        rr_e = (fifo_m.size() != 0) && ((exp_upd.size() == 0) || upd_rdy);
        chk("push_ready", 64'(bus.push_ready), 64'(pr_e));
        chk("res_ready", 64'(bus.res_ready), 64'(rr_e));
        if (exp_upd.size() != 0 && upd_rdy) begin
            void'(exp_upd.pop_front());
        end
        mp = 1'b0;
        if (rv && rr_e) begin
            h   = fifo_m[0];
            mp  = (h.taken != rt) || (h.taken && rt && (h.tgt != rtg));
            cpc = rt ? rtg : h.pc + 32'd4;
            if (mp) begin
                exp_redir.push_back(cpc);
                if (rt) exp_upd.push_back({h.pc, rtg});
                fifo_m.delete();
                mp_m++;
            end else begin
                void'(fifo_m.pop_front());
            end
        end
        if (pv && pr_e && !mp) begin
            h.pc    = ppc;
            h.taken = pt;
            h.tgt   = ptg;
            fifo_m.push_back(h);
        end
        @(posedge clk);
        @(negedge clk);
        post_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, '0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        bus.push_valid       = 1'b0;
        bus.push_pc          = '0;
        bus.push_pred_taken  = 1'b0;
        bus.push_pred_target = '0;
        bus.res_valid        = 1'b0;
        bus.res_taken        = 1'b0;
        bus.res_target       = '0;
        bus.upd_ready        = upd_rdy;
        @(posedge clk);
        @(negedge clk);
        fifo_m.delete();
        exp_redir.delete();
        exp_upd.delete();
        mp_m = 0;
        chk("rst_redirect_valid", 64'(bus.redirect_valid), 64'(0));
        chk("rst_redirect_pc", 64'(bus.redirect_pc), 64'(0));
        chk("rst_upd_valid", 64'(bus.upd_valid), 64'(0));
        chk("rst_upd_pc", 64'(bus.upd_pc), 64'(0));
        chk("rst_occupancy", 64'(occupancy), 64'(0));
        chk("rst_mp_count", 64'(mp_count), 64'(0));
        rst_n = 1'b1;
    endtask

    initial begin
        tests   = 0;
        fails   = 0;
        mp_m    = 0;
        upd_rdy = 1'b1;
        @(negedge clk);
        do_reset();

        // Not-taken prediction resolved taken: redirect + BTB install.
        cycle(1'b1, 32'h100, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h200);
        idle(1);

        // Correct taken prediction: pop only.
        cycle(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h80);

        // Predicted taken, actually not taken: fall-through redirect, no update.
        cycle(1'b1, 32'h40, 1'b1, 32'h80, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);

        // Fill, reject when full, push+pop together, then flush with a same-cycle push.
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h1000 + 32'(i * 16), 1'b1, 32'h2000, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h1100, 1'b1, 32'h2000, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h2000);
        cycle(1'b1, 32'h1200, 1'b0, '0, 1'b1, 1'b1, 32'h2000);
        cycle(1'b1, 32'h1300, 1'b0, '0, 1'b1, 1'b1, 32'h2abc);
        idle(1);

        // Update held by BTB backpressure; then back-to-back accept + new update.
        upd_rdy = 1'b0;
        cycle(1'b1, 32'h500, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h504, 1'b0, '0, 1'b1, 1'b1, 32'h600);
        cycle(1'b1, 32'h600, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b1, 32'h604, 1'b1, 32'h700, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);
        upd_rdy = 1'b1;
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h900);
        idle(2);

        // Reset mid-operation with an update pending and three records held.
        upd_rdy = 1'b0;
        cycle(1'b1, 32'h700, 1'b0, '0, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h800);
        for (int i = 0; i < 3; i++) cycle(1'b1, 32'h3000 + 32'(i * 4), 1'b0, '0, 1'b0, 1'b0, '0);
        do_reset();
        upd_rdy = 1'b1;
        idle(1);

        // Fall-through pc wraps modulo 2^ADDR_WIDTH.
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, '0);
        cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0);

        // Drive mp_count past saturation.
        for (int i = 0; i < 17; i++) begin
            cycle(1'b1, 32'(i * 8), 1'b0, '0, 1'b0, 1'b0, '0);
            cycle(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h4000 + 32'(i));
        end
        idle(1);

        // Random traffic for pointer wrap and handshake interleavings.
        for (int i = 0; i < 80; i++) begin
            upd_rdy = 1'($urandom_range(0, 1));
            cycle(1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2,
                  1'($urandom_range(0, 1)), 32'($urandom_range(1, 2)) << 4,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  32'($urandom_range(1, 2)) << 4);
        end
        upd_rdy = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
